// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and data load/store.
// Optional performance counters are enabled by defining ARB_PERF_CNT_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_access
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Outputs are gated by reset_n so every output reads 0 while reset is held.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    owner_d   = OWN_NONE;
    starve_d  = starve_q;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_sel   = 4'h0;
    mem_wdata = '0;

    if (reset_n) begin
      if (if_req && !flush && (!d_req || starve_q == STARVE_LIM)) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end

      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
      if_rvalid = (owner_q == OWN_IF) && !flush;
      d_rvalid  = (owner_q == OWN_D);
    end

    if (if_gnt) begin
      owner_d  = OWN_IF;
      mem_ce   = 1'b1;
      mem_addr = if_addr;
      mem_sel  = 4'hF;
    end else if (d_gnt) begin
      owner_d   = OWN_D;
      mem_ce    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_sel   = d_sel;
      mem_wdata = d_wdata;
    end

    // A flushed fetch request neither ages nor clears the priority counter.
    if (if_gnt || !if_req) begin
      starve_d = '0;
    end else if (!flush && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_if_stall <= '0;
      perf_d_access <= '0;
    end else begin
      if (if_req && !if_gnt && !flush) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (d_gnt) begin
        perf_d_access <= perf_d_access + 32'd1;
      end
    end
  end
`endif

endmodule
